path_arbiter: RTL and testbench

Sequential allocator between the mesh path-availability logic and the per-processor request ports. It latches transfer requests (destination, burst length) from the four processing units and checks them against the 28-bit `path_free_bits` vector, 7 candidate paths per source. One winner per grant round is chosen round-robin, and the winner gets a one-cycle response pulse plus a 3-bit path index. The allocator then holds that path for the burst length and releases it with a done pulse.

---
 rtl/path_arbiter_pkg.sv | 33 +++
 rtl/path_arbiter_path_pick.sv | 43 ++++
 rtl/path_arbiter.sv | 140 ++++++++++++++
 tb/tb_path_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/path_arbiter_pkg.sv
// Shared definitions for the path arbiter: sizes, path index constants,
// per-source FSM encoding and the latched request payload.
package path_arbiter_pkg;

  localparam int unsigned N_SRC  = 4;   // processors in the 2x2 mesh
  localparam int unsigned LEN_W  = 8;   // burst length width (beats)
  localparam int unsigned SRC_W  = 2;   // source / pointer index width
  localparam int unsigned DEST_W = 2;   // destination field width
  localparam int unsigned N_PATH = 7;   // candidate paths per source
  localparam int unsigned PIDX_W = 3;   // path index width

  // Path indices within a source's 7-bit free vector
  localparam logic [PIDX_W-1:0] PATH_SELF      = 3'd0;
  localparam logic [PIDX_W-1:0] PATH_FLAT      = 3'd1;
  localparam logic [PIDX_W-1:0] PATH_FLAT_LONG = 3'd2;
  localparam logic [PIDX_W-1:0] PATH_VERT      = 3'd3;
  localparam logic [PIDX_W-1:0] PATH_VERT_LONG = 3'd4;
  localparam logic [PIDX_W-1:0] PATH_DIAG_V    = 3'd5;
  localparam logic [PIDX_W-1:0] PATH_DIAG_H    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } src_state_e;

  // Request captured from a source while it is idle
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [LEN_W-1:0]  len;
  } src_req_t;

endpackage

// File: rtl/path_arbiter_path_pick.sv
// Candidate path selection for one source.
// Ports: src/dest select the candidate set (rel = src ^ dest), free is the
// source's 7-bit free vector; eligible_c = some candidate is free,
// idx_c = lowest free candidate index.
module path_arbiter_path_pick
  import path_arbiter_pkg::*;
(
  input  logic [SRC_W-1:0]  src,
  input  logic [DEST_W-1:0] dest,
  input  logic [N_PATH-1:0] free,
  output logic              eligible_c,
  output logic [PIDX_W-1:0] idx_c
);

  logic [SRC_W-1:0] rel;

  assign rel = src ^ dest;

  // Lowest free index within the two-path sets
  always_comb begin
    eligible_c = 1'b0;
    idx_c      = PATH_SELF;
    case (rel)
      2'd0: begin
        eligible_c = free[PATH_SELF];
        idx_c      = PATH_SELF;
      end
      2'd1: begin
        eligible_c = free[PATH_FLAT] | free[PATH_FLAT_LONG];
        idx_c      = free[PATH_FLAT] ? PATH_FLAT : PATH_FLAT_LONG;
      end
      2'd2: begin
        eligible_c = free[PATH_VERT] | free[PATH_VERT_LONG];
        idx_c      = free[PATH_VERT] ? PATH_VERT : PATH_VERT_LONG;
      end
      default: begin
        eligible_c = free[PATH_DIAG_V] | free[PATH_DIAG_H];
        idx_c      = free[PATH_DIAG_V] ? PATH_DIAG_V : PATH_DIAG_H;
      end
    endcase
  end

endmodule

// File: rtl/path_arbiter.sv
// Round-robin path allocator for four mesh sources.
// Ports: clock, reset (async active-low), path_free_bits (7 per source),
// req/req_dest/req_len (per-source request), response_signals (grant pulse),
// path_sel (3-bit index per source, held while active), active, done.
module path_arbiter
  import path_arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_SRC*N_PATH-1:0]   path_free_bits,
  input  logic [N_SRC-1:0]          req,
  input  logic [N_SRC*DEST_W-1:0]   req_dest,
  input  logic [N_SRC*LEN_W-1:0]    req_len,
  output logic [N_SRC-1:0]          response_signals,
  output logic [N_SRC*PIDX_W-1:0]   path_sel,
  output logic [N_SRC-1:0]          active,
  output logic [N_SRC-1:0]          done
);

  src_state_e              state_q [N_SRC];
  src_state_e              state_d [N_SRC];
  src_req_t                req_q   [N_SRC];
  src_req_t                req_d   [N_SRC];
  logic [LEN_W-1:0]        count_q [N_SRC];
  logic [LEN_W-1:0]        count_d [N_SRC];
  logic [SRC_W-1:0]        ptr_q, ptr_d;
  logic [N_SRC-1:0]        resp_d, active_d, done_d;
  logic [N_SRC*PIDX_W-1:0] path_sel_d;

  logic [N_SRC-1:0]        avail_c, elig_c;
  logic [PIDX_W-1:0]       pick_idx_c [N_SRC];
  logic                    found_c, grant_valid_c;
  logic [SRC_W-1:0]        cand_c, winner_c;

  // Per-source candidate lookup
  for (genvar g = 0; g < N_SRC; g++) begin : g_pick
    path_arbiter_path_pick u_pick (
      .src        (SRC_W'(g)),
      .dest       (req_q[g].dest),
      .free       (path_free_bits[g*N_PATH +: N_PATH]),
      .eligible_c (avail_c[g]),
      .idx_c      (pick_idx_c[g])
    );
    assign elig_c[g] = (state_q[g] == ST_WAIT) && avail_c[g];
  end

  // Round-robin search from ptr; blocked while a grant pulse is out so
  // path_free_bits can catch up with the previous allocation.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    cand_c   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand_c = ptr_q + SRC_W'(i);
      if (!found_c && elig_c[cand_c]) begin
        found_c  = 1'b1;
        winner_c = cand_c;
      end
    end
    grant_valid_c = found_c && !(|response_signals);
  end

  // Next-state and registered-output values for every source
  always_comb begin
    ptr_d      = ptr_q;
    resp_d     = '0;
    done_d     = '0;
    active_d   = active;
    path_sel_d = path_sel;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      state_d[s] = state_q[s];
      req_d[s]   = req_q[s];
      count_d[s] = count_q[s];
    end
    if (grant_valid_c) begin
      ptr_d = SRC_W'(winner_c + SRC_W'(1));
    end
    for (int unsigned s = 0; s < N_SRC; s++) begin
      case (state_q[s])
        ST_IDLE: begin
          // done high means the source just released; its request is dropped
          if (req[s] && !done[s] && (req_len[s*LEN_W +: LEN_W] != '0)) begin
            state_d[s]    = ST_WAIT;
            req_d[s].dest = req_dest[s*DEST_W +: DEST_W];
            req_d[s].len  = req_len[s*LEN_W +: LEN_W];
          end
        end
        ST_WAIT: begin
          if (grant_valid_c && (winner_c == SRC_W'(s))) begin
            state_d[s]                        = ST_ACTIVE;
            count_d[s]                        = req_q[s].len;
            resp_d[s]                         = 1'b1;
            active_d[s]                       = 1'b1;
            path_sel_d[s*PIDX_W +: PIDX_W]    = pick_idx_c[s];
          end
        end
        ST_ACTIVE: begin
          if (count_q[s] == LEN_W'(1)) begin
            state_d[s]                        = ST_IDLE;
            count_d[s]                        = '0;
            active_d[s]                       = 1'b0;
            done_d[s]                         = 1'b1;
            path_sel_d[s*PIDX_W +: PIDX_W]    = '0;
          end else begin
            count_d[s] = LEN_W'(count_q[s] - LEN_W'(1));
          end
        end
        default: state_d[s] = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < N_SRC; s++) begin
        state_q[s] <= ST_IDLE;
        req_q[s]   <= '0;
        count_q[s] <= '0;
      end
      ptr_q            <= '0;
      response_signals <= '0;
      active           <= '0;
      done             <= '0;
      path_sel         <= '0;
    end else begin
      for (int unsigned s = 0; s < N_SRC; s++) begin
        state_q[s] <= state_d[s];
        req_q[s]   <= req_d[s];
        count_q[s] <= count_d[s];
      end
      ptr_q            <= ptr_d;
      response_signals <= resp_d;
      active           <= active_d;
      done             <= done_d;
      path_sel         <= path_sel_d;
    end
  end

endmodule

// File: tb/tb_path_arbiter.sv
// Directed self-checking bench for path_arbiter.
module tb_path_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [27:0] path_free_bits = 28'hFFFFFFF;
  logic [3:0]  req = '0;
  logic [7:0]  req_dest = '0;
  logic [31:0] req_len = '0;
  logic [3:0]  response_signals;
  logic [11:0] path_sel;
  logic [3:0]  active;
  logic [3:0]  done;

  int checks = 0;
  int errors = 0;

  path_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .path_free_bits   (path_free_bits),
    .req              (req),
    .req_dest         (req_dest),
    .req_len          (req_len),
    .response_signals (response_signals),
    .path_sel         (path_sel),
    .active           (active),
    .done             (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [1:0] d, input logic [7:0] l);
    req[s]           = 1'b1;
    req_dest[2*s +: 2] = d;
    req_len[8*s +: 8]  = l;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_resp", 32'(response_signals), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    reset = 1'b1;
    tick();
    check("rst_done", 32'(done), 32'h0);
    check("rst_psel", 32'(path_sel), 32'h0);

    // Self transfer P0, len 3
    set_req(0, 2'd0, 8'd3);
    tick();
    req = '0;
    check("self_wait_resp", 32'(response_signals), 32'h0);
    tick();
    check("self_grant_resp", 32'(response_signals), 32'h1);
    check("self_grant_act", 32'(active), 32'h1);
    check("self_grant_psel", 32'(path_sel), 32'h0);
    tick();
    check("self_pulse_end", 32'(response_signals), 32'h0);
    check("self_act2", 32'(active), 32'h1);
    tick();
    check("self_act3", 32'(active), 32'h1);
    tick();
    check("self_act_off", 32'(active), 32'h0);
    check("self_done", 32'(done), 32'h1);
    tick();
    check("self_done_off", 32'(done), 32'h0);

    // Fallback: path 1 busy for P1, path 2 chosen
    path_free_bits[8] = 1'b0;
    set_req(1, 2'd0, 8'd2);
    tick();
    req = '0;
    tick();
    check("fb_resp", 32'(response_signals), 32'h2);
    check("fb_psel", 32'(path_sel), 32'h010);
    tick();
    check("fb_act2", 32'(active), 32'h2);
    tick();
    check("fb_done", 32'(done), 32'h2);
    tick();
    // Both candidates busy: P1 keeps waiting
    path_free_bits[9] = 1'b0;
    set_req(1, 2'd0, 8'd1);
    tick();
    req = '0;
    tick();
    check("blk_resp", 32'(response_signals), 32'h0);
    tick();
    tick();
    tick();
    check("blk_resp_late", 32'(response_signals), 32'h0);
    check("blk_active", 32'(active), 32'h0);
    path_free_bits[8] = 1'b1;
    tick();
    check("unblk_resp", 32'(response_signals), 32'h2);
    check("unblk_psel", 32'(path_sel), 32'h008);
    tick();
    check("unblk_done", 32'(done), 32'h2);
    check("unblk_act_off", 32'(active), 32'h0);
    tick();
    path_free_bits = 28'hFFFFFFF;

    // Round robin with settle cycles
    do_reset();
    set_req(0, 2'd0, 8'd1);
    set_req(1, 2'd0, 8'd1);
    set_req(2, 2'd0, 8'd1);
    set_req(3, 2'd0, 8'd1);
    tick();
    req = '0;
    tick();
    check("rr_p0", 32'(response_signals), 32'h1);
    check("rr_p0_psel", 32'(path_sel), 32'h000);
    tick();
    check("rr_settle0", 32'(response_signals), 32'h0);
    check("rr_p0_done", 32'(done), 32'h1);
    tick();
    check("rr_p1", 32'(response_signals), 32'h2);
    check("rr_p1_psel", 32'(path_sel), 32'h008);
    tick();
    check("rr_settle1", 32'(response_signals), 32'h0);
    tick();
    check("rr_p2", 32'(response_signals), 32'h4);
    check("rr_p2_psel", 32'(path_sel), 32'h0C0);
    tick();
    check("rr_settle2", 32'(response_signals), 32'h0);
    tick();
    check("rr_p3", 32'(response_signals), 32'h8);
    check("rr_p3_psel", 32'(path_sel), 32'hA00);
    tick();
    check("rr_p3_done", 32'(done), 32'h8);
    tick();

    // Ignore rules
    set_req(2, 2'd0, 8'd0);
    tick();
    req = '0;
    tick();
    tick();
    check("len0_resp", 32'(response_signals), 32'h0);
    check("len0_active", 32'(active), 32'h0);
    set_req(2, 2'd3, 8'd2);
    tick();
    req = '0;
    tick();
    check("ign_grant", 32'(response_signals), 32'h4);
    check("ign_psel", 32'(path_sel), 32'h040);
    set_req(2, 2'd0, 8'd5);
    tick();
    req = '0;
    check("ign_act2", 32'(active), 32'h4);
    tick();
    check("ign_act_off", 32'(active), 32'h0);
    check("ign_done", 32'(done), 32'h4);
    set_req(2, 2'd0, 8'd3);
    tick();
    req = '0;
    check("ign_done_off", 32'(done), 32'h0);
    tick();
    check("ign_no_regrant", 32'(response_signals), 32'h0);
    tick();
    check("ign_no_regrant2", 32'(response_signals), 32'h0);
    check("ign_idle_act", 32'(active), 32'h0);

    // Async reset in the middle of a long burst
    set_req(2, 2'd2, 8'd200);
    tick();
    req = '0;
    tick();
    check("long_act", 32'(active), 32'h4);
    check("long_psel", 32'(path_sel), 32'h0);
    repeat (49) tick();
    check("long_act50", 32'(active), 32'h4);
    reset = 1'b0;
    #1;
    check("async_active", 32'(active), 32'h0);
    check("async_resp", 32'(response_signals), 32'h0);
    check("async_done", 32'(done), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    set_req(1, 2'd1, 8'd1);
    set_req(3, 2'd3, 8'd1);
    tick();
    req = '0;
    tick();
    check("post_rst_p1", 32'(response_signals), 32'h2);
    tick();
    check("post_rst_settle", 32'(response_signals), 32'h0);
    tick();
    check("post_rst_p3", 32'(response_signals), 32'h8);
    tick();
    tick();

    // Diagonal paths for P3 -> dest 0
    path_free_bits = 28'h0C00000 << 4;
    set_req(3, 2'd0, 8'd1);
    tick();
    req = '0;
    tick();
    check("diag_resp", 32'(response_signals), 32'h8);
    check("diag_v_psel", 32'(path_sel), 32'hA00);
    tick();
    tick();
    path_free_bits = 28'h8000000;
    set_req(3, 2'd0, 8'd1);
    tick();
    req = '0;
    tick();
    check("diag_h_resp", 32'(response_signals), 32'h8);
    check("diag_h_psel", 32'(path_sel), 32'hC00);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
